// File: rtl/sync_fifo_wrap.sv
// Single-clock FWFT FIFO: head word on r_dout_o with zero read latency, flags decoded from the registered count.
// Backpressure: writes are dropped while full unless a read pops in the same cycle; reads while empty are ignored.
module sync_fifo_wrap #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 65,
  parameter int AFULL_LEVEL = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  w_en_i,
  input  logic [DATA_WIDTH-1:0] w_din_i,
  output logic [ADDR_WIDTH:0]   w_num_used_o,
  input  logic                  r_en_i,
  output logic [DATA_WIDTH-1:0] r_dout_o,
  output logic [ADDR_WIDTH:0]   r_num_val_o,
  output logic                  afull_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_fire;
  logic                  rd_fire;

  // A full FIFO is never empty, so a concurrent read always frees the slot being written.
  assign wr_fire = w_en_i & (~full_o | r_en_i);
  assign rd_fire = r_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + ONE_PTR;
    if (rd_fire) rd_ptr_d = rd_ptr_q + ONE_PTR;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= w_din_i;
  end

  assign r_dout_o     = mem_q[rd_ptr_q];
  assign w_num_used_o = count_q;
  assign r_num_val_o  = count_q;
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == DEPTH_CNT);
  assign afull_o      = (count_q >= AFULL_CNT);

endmodule

// File: tb/tb_sync_fifo_wrap.sv
// Directed bench for sync_fifo_wrap: flags, ordering, full/empty corner cases, pointer wrap and async reset.
module tb_sync_fifo_wrap;

  localparam int AW = 4;
  localparam int DW = 65;

  logic          clk;
  logic          reset_i;
  logic          w_en_i;
  logic [DW-1:0] w_din_i;
  logic [AW:0]   w_num_used_o;
  logic          r_en_i;
  logic [DW-1:0] r_dout_o;
  logic [AW:0]   r_num_val_o;
  logic          afull_o;
  logic          full_o;
  logic          empty_o;

  int total = 0;
  int bad   = 0;

  sync_fifo_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_LEVEL(8)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .w_en_i      (w_en_i),
    .w_din_i     (w_din_i),
    .w_num_used_o(w_num_used_o),
    .r_en_i      (r_en_i),
    .r_dout_o    (r_dout_o),
    .r_num_val_o (r_num_val_o),
    .afull_o     (afull_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, "_used"}, DW'(w_num_used_o), DW'(exp));
    chk({tag, "_val"}, DW'(r_num_val_o), DW'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input logic re, input logic [DW-1:0] d);
    w_en_i  = we;
    r_en_i  = re;
    w_din_i = d;
    tick();
    w_en_i  = 1'b0;
    r_en_i  = 1'b0;
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    return {1'(k & 1), 32'(k) ^ 32'hA5A5_0000, 32'(k * 3)};
  endfunction

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] big;
    logic          re;
    big     = 65'h1_2345_6789_ABCD_EF01;
    reset_i = 1'b0;
    w_en_i  = 1'b0;
    r_en_i  = 1'b0;
    w_din_i = '0;
    #12;
    chk("rst_empty", DW'(empty_o), 1);
    chk("rst_full", DW'(full_o), 0);
    chk("rst_afull", DW'(afull_o), 0);
    chk_cnt("rst_cnt", 0);
    reset_i = 1'b1;

    // single word round trip, visible without r_en_i
    cyc(1'b1, 1'b0, 65'hA5);
    chk("one_empty", DW'(empty_o), 0);
    chk_cnt("one_cnt", 1);
    chk("one_dout", r_dout_o, 65'hA5);
    cyc(1'b0, 1'b1, '0);
    chk("one_pop_empty", DW'(empty_o), 1);
    chk_cnt("one_pop_cnt", 0);

    // fill to full, watch afull/full thresholds
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, DW'(i));
      chk("fill_afull", DW'(afull_o), DW'(i + 1 >= 8));
      chk("fill_full", DW'(full_o), DW'(i + 1 == 16));
      chk_cnt("fill_cnt", i + 1);
    end
    cyc(1'b1, 1'b0, 65'h99);
    chk("drop_full", DW'(full_o), 1);
    chk_cnt("drop_cnt", 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", r_dout_o, DW'(i));
      cyc(1'b0, 1'b1, '0);
    end
    chk("drain_empty", DW'(empty_o), 1);
    chk_cnt("drain_cnt", 0);

    // simultaneous write+read while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, DW'(i));
    chk("wrf_head", r_dout_o, 0);
    cyc(1'b1, 1'b1, 65'h1FF);
    chk_cnt("wrf_cnt", 16);
    chk("wrf_full", DW'(full_o), 1);
    for (int i = 1; i < 16; i++) begin
      chk("wrf_dout", r_dout_o, DW'(i));
      cyc(1'b0, 1'b1, '0);
    end
    chk("wrf_last", r_dout_o, 65'h1FF);
    cyc(1'b0, 1'b1, '0);
    chk("wrf_empty", DW'(empty_o), 1);

    // simultaneous write+read while empty
    cyc(1'b1, 1'b1, big);
    chk_cnt("wre_cnt", 1);
    chk("wre_dout", r_dout_o, big);
    cyc(1'b0, 1'b1, '0);
    chk("wre_empty", DW'(empty_o), 1);

    // reads while empty are ignored
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk_cnt("rde_cnt", 0);
      chk("rde_empty", DW'(empty_o), 1);
    end
    cyc(1'b1, 1'b0, 65'h77);
    chk("rde_rt_dout", r_dout_o, 65'h77);
    cyc(1'b0, 1'b1, '0);
    chk("rde_rt_empty", DW'(empty_o), 1);

    // 40 words with interleaved reads, wrapping the pointers
    for (int k = 0; k < 40; k++) begin
      re = (k % 3 != 0) && (q.size() > 0);
      if (re) begin
        chk("wrap_dout", r_dout_o, q[0]);
        void'(q.pop_front());
      end
      q.push_back(pat(k));
      cyc(1'b1, re, pat(k));
      chk_cnt("wrap_cnt", q.size());
    end
    chk("wrap_afull", DW'(afull_o), DW'(q.size() >= 8));
    chk("wrap_head", r_dout_o, q[0]);

    // async reset mid-stream: flags clear before any clock edge
    @(posedge clk);
    #2;
    reset_i = 1'b0;
    #1;
    chk("arst_empty", DW'(empty_o), 1);
    chk("arst_afull", DW'(afull_o), 0);
    chk("arst_full", DW'(full_o), 0);
    chk_cnt("arst_cnt", 0);
    cyc(1'b1, 1'b0, 65'h55);
    chk_cnt("arst_ign_cnt", 0);
    reset_i = 1'b1;
    cyc(1'b1, 1'b0, 65'h1_0000_0000_0000_0033);
    chk_cnt("resume_cnt", 1);
    chk("resume_dout", r_dout_o, 65'h1_0000_0000_0000_0033);
    cyc(1'b0, 1'b1, '0);
    chk("resume_empty", DW'(empty_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
